uart_tx_framer: RTL

Transmit framer for the UART datapath, directly downstream of the transmit `sc_fifo`. It pops one word at a time from the FIFO and serialises it on `tx`. Each frame is a start bit, data LSB-first, an optional parity bit, and one or two stop bits. Bit period is runtime-programmable in clock cycles.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_bit_timer.sv | 28 ++
 rtl/uart_tx_framer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit framer and the receiver.
package uart_pkg;

  // Legal number of data bits per frame.
  localparam int UART_DATA_WIDTH_MIN = 5;
  localparam int UART_DATA_WIDTH_MAX = 9;

  // Serial line level when no frame is in flight.
  localparam logic UART_IDLE = 1'b1;

  typedef enum logic [2:0] {
    UART_TX_IDLE   = 3'd0,
    UART_TX_FETCH  = 3'd1,
    UART_TX_START  = 3'd2,
    UART_TX_DATA   = 3'd3,
    UART_TX_PARITY = 3'd4,
    UART_TX_STOP   = 3'd5
  } uart_tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clk cycles from 0 up to div, pulsing tick on the
// terminal count so one bit period is div+1 cycles. Shared with the receiver.
module uart_bit_timer #(
  parameter int div_width = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 restart,
  input  logic [div_width-1:0] div,
  output logic                 tick
);

  logic [div_width-1:0] cnt_q;

  assign tick = (cnt_q == div);

  // Up-counter, cleared by restart and wrapped on the terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (restart || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: pops words from the transmit FIFO and serialises them
// as start / data (LSB first) / optional parity / one or two stop bits.
//
// state  | meaning
// IDLE   | line high, pop the FIFO when enabled and not empty
// FETCH  | capture FIFO word and frame configuration, drive start bit
// START  | start bit (low) on the line
// DATA   | data bits, LSB first
// PARITY | parity bit
// STOP   | stop bit(s), line high
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int data_width = 8,
  parameter int div_width  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [div_width-1:0]  baud_div,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  stop2,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [data_width-1:0] fifo_data,
  output logic                  tx,
  output logic                  busy
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(data_width - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (data_width < UART_DATA_WIDTH_MIN || data_width > UART_DATA_WIDTH_MAX) begin : g_bad_width
    $error("uart_tx_framer: data_width out of range");
  end

  uart_tx_state_t        state_q;
  logic                  tx_q;
  logic [data_width-1:0] shift_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  parity_q;
  logic [div_width-1:0]  div_q;
  logic                  par_en_q;
  logic                  stop2_q;
  logic                  tick;
  logic                  timer_restart;
  logic                  pop;

  // Qualified by reset_n so the pop strobe drops the instant reset asserts,
  // even though IDLE is also the reset state.
  assign pop = reset_n && (state_q == UART_TX_IDLE) && enable && !fifo_empty;

  assign fifo_rd = pop;
  assign tx      = tx_q;
  assign busy    = (state_q != UART_TX_IDLE);

  // Hold the timer at zero until the frame starts so START gets a full period.
  assign timer_restart = (state_q == UART_TX_IDLE) || (state_q == UART_TX_FETCH);

  uart_bit_timer #(
    .div_width(div_width)
  ) u_bit_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (timer_restart),
    .div     (div_q),
    .tick    (tick)
  );

  // Frame sequencer: state, line driver, shift register, bit and stop counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= UART_TX_IDLE;
      tx_q      <= UART_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      div_q     <= '0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      case (state_q)
        UART_TX_IDLE: begin
          tx_q      <= UART_IDLE;
          bit_cnt_q <= '0;
          if (pop) state_q <= UART_TX_FETCH;
        end
        UART_TX_FETCH: begin
          shift_q  <= fifo_data;
          div_q    <= baud_div;
          par_en_q <= parity_en;
          stop2_q  <= stop2;
          parity_q <= (^fifo_data) ^ parity_odd;
          tx_q     <= 1'b0;
          state_q  <= UART_TX_START;
        end
        UART_TX_START: begin
          if (tick) begin
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= '0;
            state_q   <= UART_TX_DATA;
          end
        end
        UART_TX_DATA: begin
          if (tick) begin
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              if (par_en_q) begin
                tx_q    <= parity_q;
                state_q <= UART_TX_PARITY;
              end else begin
                tx_q    <= UART_IDLE;
                state_q <= UART_TX_STOP;
              end
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        UART_TX_PARITY: begin
          if (tick) begin
            tx_q      <= UART_IDLE;
            bit_cnt_q <= '0;
            state_q   <= UART_TX_STOP;
          end
        end
        UART_TX_STOP: begin
          if (tick) begin
            if (!stop2_q || bit_cnt_q == CNT_ONE) begin
              bit_cnt_q <= '0;
              state_q   <= UART_TX_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          tx_q    <= UART_IDLE;
          state_q <= UART_TX_IDLE;
        end
      endcase
    end
  end

endmodule
